// File: rtl/mix_column_p2s_serializer.sv
// Parallel-to-serial stage behind MixColumns: takes one column every
// NUM_ROWS byte slots and streams a full 16-byte AES state one byte per
// transfer. It also owns the byte index within the state.
//
// state | meaning
// IDLE  | waiting for start; all outputs quiet
// SHIFT | streaming bytes; a column is loaded on every row-0 slot
// DONE  | one-cycle completion pulse after byte 15 has transferred
module mix_column_p2s_serializer #(
  parameter int BYTE_W   = 8,
  parameter int NUM_ROWS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [BYTE_W*NUM_ROWS-1:0] i_col_in,
  input  logic                       i_out_ready,
  output logic [BYTE_W-1:0]          o_byte_out,
  output logic                       o_byte_valid,
  output logic                       o_en_parallel_load,
  output logic [3:0]                 o_inner_state_counter,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int COL_W     = BYTE_W * NUM_ROWS;
  localparam int ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [COL_W-1:0] r_shreg;
  logic             r_valid;
  logic             r_load;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_cnt_inc;
  logic             w_xfer;
  logic [BYTE_W-1:0] w_byte_out;

  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_xfer    = r_valid & i_out_ready;

  // Sequencer: state, byte index, shift register and registered status flags.
  // The load flag for the next slot is precomputed from the incremented index
  // so en_parallel_load is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_shreg <= '0;
      r_valid <= 1'b0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= SHIFT;
            r_cnt   <= 4'd0;
            r_valid <= 1'b1;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            // On a load slot row 0 goes straight out, so only the lower rows are kept.
            if (r_load) begin
              r_shreg <= {i_col_in[COL_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            end else begin
              r_shreg <= r_shreg << BYTE_W;
            end
            r_cnt <= w_cnt_inc;
            if (r_cnt == 4'd15) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_load  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_load <= (w_cnt_inc[ROW_IDX_W-1:0] == '0);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
          r_valid <= 1'b0;
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Output byte: row 0 of the incoming column passes through on load slots,
  // otherwise the top of the shift register; zero whenever not streaming.
  always_comb begin
    w_byte_out = '0;
    if (r_load) begin
      w_byte_out = i_col_in[COL_W-1 -: BYTE_W];
    end else if (r_valid) begin
      w_byte_out = r_shreg[COL_W-1 -: BYTE_W];
    end
  end

  assign o_byte_out            = w_byte_out;
  assign o_byte_valid          = r_valid;
  assign o_en_parallel_load    = r_load;
  assign o_inner_state_counter = r_cnt;
  assign o_busy                = r_busy;
  assign o_done                = r_done;

endmodule

// File: tb/tb_mix_column_p2s_serializer.sv
// Bench for mix_column_p2s_serializer: a reference model tracks the
// serializer phase at the transaction level, generates column data when a
// start is accepted and queues the expected byte stream; a monitor compares
// every observed cycle against it.
module tb_mix_column_p2s_serializer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_col_in;
  logic        i_out_ready;
  logic [7:0]  o_byte_out;
  logic        o_byte_valid;
  logic        o_en_parallel_load;
  logic [3:0]  o_inner_state_counter;
  logic        o_busy;
  logic        o_done;

  mix_column_p2s_serializer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_start               (i_start),
    .i_col_in              (i_col_in),
    .i_out_ready           (i_out_ready),
    .o_byte_out            (o_byte_out),
    .o_byte_valid          (o_byte_valid),
    .o_en_parallel_load    (o_en_parallel_load),
    .o_inner_state_counter (o_inner_state_counter),
    .o_busy                (o_busy),
    .o_done                (o_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_phase = 0;   // 0 idle, 1 streaming, 2 completion cycle
  int          m_idx   = 0;   // bytes transferred in the current state
  int          m_states_done = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] col_mem[$];
  logic [31:0] fixed_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer: presents the next pending column, advancing only after a
  // load transfer has been consumed.
  always @(posedge clk) begin
    #1;
    i_col_in = (col_mem.size() > 0) ? col_mem[0] : 32'hDEAD_BEEF;
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_byte_out", {24'd0, o_byte_out}, 32'd0);
      check("rst_valid", {31'd0, o_byte_valid}, 32'd0);
      check("rst_load", {31'd0, o_en_parallel_load}, 32'd0);
      check("rst_cnt", {28'd0, o_inner_state_counter}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      m_phase = 0;
      m_idx   = 0;
      exp_q.delete();
      col_mem.delete();
    end else begin
      case (m_phase)
        0: begin
          check("idle_valid", {31'd0, o_byte_valid}, 32'd0);
          check("idle_busy", {31'd0, o_busy}, 32'd0);
          check("idle_done", {31'd0, o_done}, 32'd0);
          check("idle_byte", {24'd0, o_byte_out}, 32'd0);
          check("idle_cnt", {28'd0, o_inner_state_counter}, 32'd0);
          check("idle_load", {31'd0, o_en_parallel_load}, 32'd0);
          if (i_start) begin
            for (int c = 0; c < 4; c++) begin
              logic [31:0] col;
              col = (fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
              col_mem.push_back(col);
              for (int r = 0; r < 4; r++)
                exp_q.push_back(8'((col >> (24 - 8 * r)) & 32'hFF));
            end
            m_phase = 1;
            m_idx   = 0;
          end
        end
        1: begin
          check("shift_valid", {31'd0, o_byte_valid}, 32'd1);
          check("shift_busy", {31'd0, o_busy}, 32'd1);
          check("shift_done", {31'd0, o_done}, 32'd0);
          check("shift_cnt", {28'd0, o_inner_state_counter}, 32'(m_idx));
          check("shift_load", {31'd0, o_en_parallel_load}, (m_idx % 4 == 0) ? 32'd1 : 32'd0);
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
          end else begin
            check("byte_out", {24'd0, o_byte_out}, {24'd0, exp_q[0]});
            if (i_out_ready) begin
              void'(exp_q.pop_front());
              if (m_idx % 4 == 0 && col_mem.size() > 0) void'(col_mem.pop_front());
              m_idx++;
              if (m_idx == 16) m_phase = 2;
            end
          end
        end
        default: begin
          check("done_pulse", {31'd0, o_done}, 32'd1);
          check("done_busy", {31'd0, o_busy}, 32'd1);
          check("done_valid", {31'd0, o_byte_valid}, 32'd0);
          check("done_cnt", {28'd0, o_inner_state_counter}, 32'd0);
          check("done_byte", {24'd0, o_byte_out}, 32'd0);
          m_states_done++;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_cnt(input logic [3:0] v);
    int k = 0;
    while (o_inner_state_counter !== v && k < 60) begin
      tick(1);
      k++;
    end
    if (k >= 60) check("wait_cnt_timeout", {28'd0, o_inner_state_counter}, {28'd0, v});
  endtask

  task automatic wait_done(input bit rand_ready);
    int k = 0;
    while (o_done !== 1'b1 && k < 300) begin
      if (rand_ready) i_out_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    if (k >= 300) check("wait_done_timeout", {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    int expect_states;
    rst_n       = 1'b1;
    i_start     = 1'b0;
    i_out_ready = 1'b1;
    i_col_in    = 32'h0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // known-answer stream 00..FF with no back-pressure
    fixed_q.push_back(32'h0011_2233);
    fixed_q.push_back(32'h4455_6677);
    fixed_q.push_back(32'h8899_AABB);
    fixed_q.push_back(32'hCCDD_EEFF);
    pulse_start();
    wait_done(1'b0);
    tick(2);

    // stall mid-column
    pulse_start();
    wait_cnt(4'd5);
    i_out_ready = 1'b0;
    tick(3);
    i_out_ready = 1'b1;
    wait_done(1'b0);
    tick(2);

    // stall on a load slot
    pulse_start();
    wait_cnt(4'd8);
    i_out_ready = 1'b0;
    tick(3);
    i_out_ready = 1'b1;
    wait_done(1'b0);
    tick(2);

    // start while streaming and during DONE must be ignored
    pulse_start();
    wait_cnt(4'd7);
    pulse_start();
    wait_done(1'b0);
    pulse_start();
    tick(3);

    // reset in the middle of a state, then replay
    pulse_start();
    wait_cnt(4'd10);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    wait_done(1'b0);
    tick(1);

    // back-to-back states, second start in the first IDLE cycle
    pulse_start();
    wait_done(1'b0);
    tick(1);
    pulse_start();
    wait_done(1'b0);
    tick(2);

    // randomized back-pressure
    for (int s = 0; s < 6; s++) begin
      i_out_ready = 1'($urandom_range(0, 1));
      pulse_start();
      wait_done(1'b1);
      tick(1 + int'($urandom_range(0, 2)));
    end
    i_out_ready = 1'b1;
    tick(3);

    // known-answer, stall, ignored-start, post-reset, two back-to-back, six random
    expect_states = 1 + 1 + 1 + 1 + 1 + 2 + 6;
    check("states_completed", 32'(m_states_done), 32'(expect_states));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
